// File: rtl/alu_unit_if.sv
// Operand/result bundle for alu_unit: master drives operands and opcode, slave returns result and flags.
// Carry_Flag exists only when ALU_CARRY_EN is defined.
interface alu_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_FUN;
  logic [WIDTH-1:0] ALU_OUT;
  logic             Arith_Flag;
  logic             Logic_Flag;
  logic             CMP_Flag;
  logic             Shift_Flag;
`ifdef ALU_CARRY_EN
  logic             Carry_Flag;
`endif

  modport master (
    output A, B, ALU_FUN,
    input  ALU_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag
`ifdef ALU_CARRY_EN
    , input Carry_Flag
`endif
  );

  modport slave (
    input  A, B, ALU_FUN,
    output ALU_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag
`ifdef ALU_CARRY_EN
    , output Carry_Flag
`endif
  );
endinterface

// File: rtl/alu_unit.sv
// Registered 16-function ALU: one-cycle latency, one-hot class flags decoded from the opcode.
// Optional macro ALU_CARRY_EN adds a registered Carry_Flag (add carry, subtract borrow, multiply overflow).
module alu_unit #(
  parameter int WIDTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  alu_unit_if.slave  bus
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quot;
  logic             w_eq;
  logic             w_gt;
  logic             w_lt;
  logic [WIDTH-1:0] w_result;
  logic [3:0]       w_flags;   // {arith, logic, cmp, shift}

  logic [WIDTH-1:0] r_alu_out;
  logic [3:0]       r_flags;

`ifdef ALU_CARRY_EN
  logic                 w_add_c;
  logic [2*WIDTH-1:0]   w_prod_full;
  logic                 w_mul_ovf;
  logic                 w_carry;
  logic                 r_carry;

  assign {w_add_c, w_sum} = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_prod_full      = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
  assign w_prod           = w_prod_full[WIDTH-1:0];
  assign w_mul_ovf        = |w_prod_full[2*WIDTH-1:WIDTH];
`else
  assign w_sum  = bus.A + bus.B;
  assign w_prod = bus.A * bus.B;
`endif

  assign w_diff = bus.A - bus.B;
  // Divide-by-zero yields zero rather than the all-ones a raw divider might produce.
  assign w_quot = (bus.B == {WIDTH{1'b0}}) ? {WIDTH{1'b0}} : (bus.A / bus.B);
  assign w_eq   = (bus.A == bus.B);
  assign w_gt   = (bus.A >  bus.B);
  assign w_lt   = (bus.A <  bus.B);

  // Opcode decode: next result and class flags; unknown opcodes fall to the zero default.
  always_comb begin
    w_result = {WIDTH{1'b0}};
    w_flags  = 4'b0000;
    case (bus.ALU_FUN)
      4'b0000: begin w_result = w_sum;                   w_flags = 4'b1000; end
      4'b0001: begin w_result = w_diff;                  w_flags = 4'b1000; end
      4'b0010: begin w_result = w_prod;                  w_flags = 4'b1000; end
      4'b0011: begin w_result = w_quot;                  w_flags = 4'b1000; end
      4'b0100: begin w_result = bus.A & bus.B;           w_flags = 4'b0100; end
      4'b0101: begin w_result = bus.A | bus.B;           w_flags = 4'b0100; end
      4'b0110: begin w_result = ~(bus.A & bus.B);        w_flags = 4'b0100; end
      4'b0111: begin w_result = ~(bus.A | bus.B);        w_flags = 4'b0100; end
      4'b1000: begin w_result = bus.A ^ bus.B;           w_flags = 4'b0100; end
      4'b1001: begin w_result = ~(bus.A ^ bus.B);        w_flags = 4'b0100; end
      4'b1010: begin w_result = w_eq ? WIDTH'(1) : {WIDTH{1'b0}}; w_flags = 4'b0010; end
      4'b1011: begin w_result = w_gt ? WIDTH'(2) : {WIDTH{1'b0}}; w_flags = 4'b0010; end
      4'b1100: begin w_result = w_lt ? WIDTH'(3) : {WIDTH{1'b0}}; w_flags = 4'b0010; end
      4'b1101: begin w_result = {1'b0, bus.A[WIDTH-1:1]}; w_flags = 4'b0001; end
      4'b1110: begin w_result = {bus.A[WIDTH-2:0], 1'b0}; w_flags = 4'b0001; end
      default: begin w_result = {WIDTH{1'b0}};           w_flags = 4'b0000; end
    endcase
  end

`ifdef ALU_CARRY_EN
  // Carry/borrow/overflow select for the arithmetic ops that define one.
  always_comb begin
    w_carry = 1'b0;
    case (bus.ALU_FUN)
      4'b0000: w_carry = w_add_c;
      4'b0001: w_carry = w_lt;
      4'b0010: w_carry = w_mul_ovf;
      default: w_carry = 1'b0;
    endcase
  end

  // Carry register, same timing and reset as the main result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_carry <= 1'b0;
    end else begin
      r_carry <= w_carry;
    end
  end

  assign bus.Carry_Flag = r_carry;
`endif

  // Result and flag registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_alu_out <= {WIDTH{1'b0}};
      r_flags   <= 4'b0000;
    end else begin
      r_alu_out <= w_result;
      r_flags   <= w_flags;
    end
  end

  assign bus.ALU_OUT    = r_alu_out;
  assign bus.Arith_Flag = r_flags[3];
  assign bus.Logic_Flag = r_flags[2];
  assign bus.CMP_Flag   = r_flags[1];
  assign bus.Shift_Flag = r_flags[0];

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit with hand-computed expectations.
// Build with +define+ALU_CARRY_EN to also check Carry_Flag.
module tb_alu_unit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  alu_unit_if #(.WIDTH(16)) u_bus ();

  alu_unit #(.WIDTH(16)) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (u_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] obs_flags();
    return {u_bus.Arith_Flag, u_bus.Logic_Flag, u_bus.CMP_Flag, u_bus.Shift_Flag};
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one op, clock it, then check result, flags (and carry when built in).
  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] fun, input logic [15:0] exp,
                       input logic [3:0] flg, input logic cy);
    u_bus.A       = a;
    u_bus.B       = b;
    u_bus.ALU_FUN = fun;
    @(posedge clk);
    #1;
    check_vec({tag, ".out"}, 32'(u_bus.ALU_OUT), 32'(exp));
    check_vec({tag, ".flags"}, 32'(obs_flags()), 32'(flg));
`ifdef ALU_CARRY_EN
    check_vec({tag, ".carry"}, 32'(u_bus.Carry_Flag), 32'(cy));
`else
    if (cy === 1'bx) $display("unexpected unknown carry expectation in %s", tag);
`endif
  endtask

  logic [15:0] sweep_out [16];
  logic [3:0]  sweep_flg [16];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    u_bus.A       = 16'd0;
    u_bus.B       = 16'd0;
    u_bus.ALU_FUN = 4'b0000;

    // A=20, B=10 through every opcode
    sweep_out = '{16'd30, 16'd10, 16'd200, 16'd2, 16'd0, 16'd30, 16'hFFFF, 16'hFFE1,
                  16'd30, 16'hFFE1, 16'd0, 16'd2, 16'd0, 16'd10, 16'd40, 16'd0};
    sweep_flg = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                  4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0000};

    #12;
    check_vec("reset.out", 32'(u_bus.ALU_OUT), 32'd0);
    check_vec("reset.flags", 32'(obs_flags()), 32'd0);
    rst = 1'b0;

    // Asynchronous reset mid-cycle, and held across an edge
    apply("rst_pre", 16'd10, 16'd10, 4'b0000, 16'd20, 4'b1000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_vec("async_rst.out", 32'(u_bus.ALU_OUT), 32'd0);
    check_vec("async_rst.flags", 32'(obs_flags()), 32'd0);
    @(posedge clk);
    #1;
    check_vec("rst_hold.out", 32'(u_bus.ALU_OUT), 32'd0);
    check_vec("rst_hold.flags", 32'(obs_flags()), 32'd0);
    #2;
    rst = 1'b0;

    // Arithmetic
    apply("add",      16'd10,   16'd10, 4'b0000, 16'd20,   4'b1000, 1'b0);
    apply("sub",      16'd20,   16'd10, 4'b0001, 16'd10,   4'b1000, 1'b0);
    apply("mul",      16'd10,   16'd10, 4'b0010, 16'd100,  4'b1000, 1'b0);
    apply("div",      16'd100,  16'd5,  4'b0011, 16'd20,   4'b1000, 1'b0);
    apply("add_wrap", 16'hFFFF, 16'd1,  4'b0000, 16'd0,    4'b1000, 1'b1);
    apply("div_zero", 16'd5,    16'd0,  4'b0011, 16'd0,    4'b1000, 1'b0);
    apply("sub_wrap", 16'd5,    16'd9,  4'b0001, 16'hFFFC, 4'b1000, 1'b1);
    apply("mul_ovf",  16'h0100, 16'h0100, 4'b0010, 16'd0,  4'b1000, 1'b1);
    // Logic
    apply("and",  16'd18, 16'd10, 4'b0100, 16'd2,    4'b0100, 1'b0);
    apply("or",   16'd23, 16'd14, 4'b0101, 16'd31,   4'b0100, 1'b0);
    apply("nand", 16'd9,  16'd3,  4'b0110, 16'hFFFE, 4'b0100, 1'b0);
    apply("nor",  16'd9,  16'd3,  4'b0111, 16'hFFF4, 4'b0100, 1'b0);
    apply("xor",  16'd73, 16'd23, 4'b1000, 16'd94,   4'b0100, 1'b0);
    apply("xnor", 16'd9,  16'd3,  4'b1001, 16'hFFF5, 4'b0100, 1'b0);
    // Compare
    apply("eq",    16'd20, 16'd20, 4'b1010, 16'd1, 4'b0010, 1'b0);
    apply("gt",    16'd40, 16'd20, 4'b1011, 16'd2, 4'b0010, 1'b0);
    apply("lt_f",  16'd40, 16'd20, 4'b1100, 16'd0, 4'b0010, 1'b0);
    apply("lt_t",  16'd5,  16'd9,  4'b1100, 16'd3, 4'b0010, 1'b0);
    apply("eq_f",  16'd5,  16'd9,  4'b1010, 16'd0, 4'b0010, 1'b0);
    // Shift and default
    apply("shr",     16'd20,   16'd0, 4'b1101, 16'd10,     4'b0001, 1'b0);
    apply("shl",     16'd20,   16'd0, 4'b1110, 16'd40,     4'b0001, 1'b0);
    apply("shl_msb", 16'h8001, 16'd0, 4'b1110, 16'h0002,   4'b0001, 1'b0);
    apply("shr_msb", 16'h8001, 16'd0, 4'b1101, 16'h4000,   4'b0001, 1'b0);
    apply("nop",     16'd2,    16'd2, 4'b1111, 16'd0,      4'b0000, 1'b0);

    // Back-to-back opcode sweep: each result lands exactly one edge after it is applied
    u_bus.A = 16'd20;
    u_bus.B = 16'd10;
    u_bus.ALU_FUN = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      check_vec($sformatf("sweep%0d.out", i), 32'(u_bus.ALU_OUT), 32'(sweep_out[i]));
      check_vec($sformatf("sweep%0d.flags", i), 32'(obs_flags()), 32'(sweep_flg[i]));
      u_bus.ALU_FUN = 4'((i + 1) % 16);
      #1;
      check_vec($sformatf("sweep%0d.hold", i), 32'(u_bus.ALU_OUT), 32'(sweep_out[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Registered 16-bit ALU with 16 functions selected by a 4-bit opcode: arithmetic, logic, compare and shift.
- Result and four one-hot class flags are registered on the rising edge of CLK.
- Used as a datapath execution unit; operands and opcode are driven from upstream registers.

Parameters:
- WIDTH, 16, operand and result width in bits. All behaviour below is specified for WIDTH=16.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  asynchronous reset, active-high.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- ALU_FUN  input  4  function select.
- ALU_OUT  output  WIDTH  registered result.
- Arith_Flag  output  1  registered; 1 when the registered op is arithmetic.
- Logic_Flag  output  1  registered; 1 when the registered op is logic.
- CMP_Flag  output  1  registered; 1 when the registered op is a compare.
- Shift_Flag  output  1  registered; 1 when the registered op is a shift.

Behaviour:
- Reset: RST=1 asynchronously clears ALU_OUT and all flags to 0. Reset dominates any clock edge.
- Latency: 1 cycle. A, B and ALU_FUN sampled at rising edge N appear on ALU_OUT and the flags after edge N. Inputs are not otherwise registered.
- No handshake. A new operation is accepted every cycle.
- ALU_FUN decode (ALU_OUT / flag set):
  - 0000: A+B, truncated to WIDTH (wraps) / Arith.
  - 0001: A-B, modulo 2^WIDTH (wraps) / Arith.
  - 0010: A*B, low WIDTH bits / Arith.
  - 0011: A/B, unsigned integer quotient; B=0 gives 0 / Arith.
  - 0100: A&B / Logic.
  - 0101: A|B / Logic.
  - 0110: ~(A&B) / Logic.
  - 0111: ~(A|B) / Logic.
  - 1000: A^B / Logic.
  - 1001: ~(A^B) / Logic.
  - 1010: 1 if A==B, else 0 / CMP.
  - 1011: 2 if A>B (unsigned), else 0 / CMP.
  - 1100: 3 if A<B (unsigned), else 0 / CMP.
  - 1101: A>>1, logical, MSB filled with 0 / Shift.
  - 1110: A<<1, LSB filled with 0 / Shift.
  - 1111: 0 / all flags 0.
- Flags are one-hot (or all zero for 1111) and are derived purely from ALU_FUN, never from the result value.
- Compare ops give ALU_OUT=0 when the condition is false; CMP_Flag stays 1.
- X/Z on ALU_FUN: the default branch applies (ALU_OUT=0, flags 0).

Optional Feature:
- Macro: ALU_CARRY_EN.
- Defined: adds output Carry_Flag (1 bit), registered with the same 1-cycle latency and cleared by RST.
  - 0000: Carry_Flag = carry out of A+B.
  - 0001: Carry_Flag = borrow, i.e. 1 when A<B.
  - 0010: Carry_Flag = 1 when the upper WIDTH bits of the full product are non-zero.
  - All other ops: Carry_Flag = 0.
- Not defined: port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert RST mid-cycle with ALU_OUT=20 and Arith_Flag=1 -> ALU_OUT=0 and all flags 0 immediately, without waiting for a clock edge.
- Arithmetic: A=10,B=10,0000 -> 20 after one edge, flags {A,L,C,S}=1000. A=20,B=10,0001 -> 10. A=10,B=10,0010 -> 100. A=100,B=5,0011 -> 20. A=0xFFFF,B=1,0000 -> 0 (wrap). A=5,B=0,0011 -> 0.
- Logic, flags 0100: A=18,B=10,0100 -> 2. A=23,B=14,0101 -> 31. A=9,B=3,0110 -> 0xFFFE. A=9,B=3,0111 -> 0xFFF4. A=73,B=23,1000 -> 94. A=9,B=3,1001 -> 0xFFF5.
- Compare, flags 0010: A=20,B=20,1010 -> 1. A=40,B=20,1011 -> 2. A=40,B=20,1100 -> 0. A=5,B=9,1100 -> 3.
- Shift and default: A=20,1101 -> 10, flags 0001. A=20,1110 -> 40, flags 0001. A=0x8001,1110 -> 0x0002. A=2,B=2,1111 -> 0, flags 0000.
- Latency: change ALU_FUN every cycle through 0000..1111 -> each result and flag set appears exactly one edge after it is applied, with no stale flag bits.
